axi4_mem_slave: RTL and testbench

//  AXI4 memory-mapped slave wrapping a single-port word memory of DEPTH x DATA_WIDTH.

---
 rtl/axi4_mem_slave.sv | 218 +++++++++++++++++++++
 tb/tb_axi4_mem_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave
//   AXI4 slave in front of a single-port DEPTH x DATA_WIDTH word memory. It accepts
//   INCR bursts on independent write (AW/W/B) and read (AR/R) channels. Bursts that
//   are illegal are answered with SLVERR. Only one write burst and one read burst
//   can be in flight at a time.
// Ports
//   ACLK, ARESET                    clock; synchronous active-high reset
//   AWADDR/AWLEN/AWSIZE/AWVALID/AWREADY   write address channel
//   WDATA/WLAST/WVALID/WREADY             write data channel
//   BRESP/BVALID/BREADY                   write response channel
//   ARADDR/ARLEN/ARSIZE/ARVALID/ARREADY   read address channel
//   RDATA/RRESP/RLAST/RVALID/RREADY       read data channel
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for AW; AWREADY high once out of reset
//   W_DATA | accepting len+1 W beats
//   W_RESP | presenting B until BREADY
// Read FSM
//   state   | meaning
//   R_IDLE  | waiting for AR; ARREADY high once out of reset
//   R_FETCH | memory read issued, retried if a write owns the port
//   R_DATA  | presenting R beat until RREADY
module axi4_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SUM_W = ADDR_WIDTH + 11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  // Last byte of the burst is computed wide enough that it cannot wrap, so a
  // burst running past the end of the memory is always caught.
  function automatic logic burst_bad(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [7:0] len,
                                     input logic [2:0] size);
    logic [SUM_W-1:0] last_byte;
    last_byte = SUM_W'(addr) + (SUM_W'(len) + SUM_W'(1)) * SUM_W'(4) - SUM_W'(1);
    return (size != 3'd2) || (addr[1:0] != 2'b00) || (last_byte >= SUM_W'(4 * DEPTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Ready outputs stay low until the first edge after reset is released.
  logic up_q;

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_err_q, w_err_d;    // address-phase error, blocks writes
  logic                  w_lerr_q, w_lerr_d;  // WLAST mismatch, response only

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  r_err_q, r_err_d;

  logic mem_we;
  logic mem_re;

  // The write owns the port; a pending fetch waits a cycle and then sees the new data.
  assign mem_we = !ARESET && (w_state_q == W_DATA) && WVALID && !w_err_q;
  assign mem_re = !ARESET && (r_state_q == R_FETCH) && !mem_we;

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    w_lerr_d  = w_lerr_q;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BRESP     = 2'b00;
    unique case (w_state_q)
      W_IDLE: begin
        AWREADY = up_q;
        if (AWVALID && up_q) begin
          w_addr_d  = AWADDR;
          w_len_d   = AWLEN;
          w_cnt_d   = 8'd0;
          w_err_d   = burst_bad(AWADDR, AWLEN, AWSIZE);
          w_lerr_d  = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          w_addr_d = w_addr_q + ADDR_WIDTH'(4);
          w_cnt_d  = w_cnt_q + 8'd1;
          if (WLAST != (w_cnt_q == w_len_q)) w_lerr_d = 1'b1;
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        BRESP  = (w_err_q || w_lerr_q) ? 2'b10 : 2'b00;
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_err_d   = r_err_q;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RDATA     = '0;
    RRESP     = 2'b00;
    RLAST     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ARREADY = up_q;
        if (ARVALID && up_q) begin
          r_addr_d  = ARADDR;
          r_len_d   = ARLEN;
          r_cnt_d   = 8'd0;
          r_err_d   = burst_bad(ARADDR, ARLEN, ARSIZE);
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        if (!mem_we) r_state_d = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        RDATA  = r_err_q ? '0 : rdata_q;
        RRESP  = r_err_q ? 2'b10 : 2'b00;
        RLAST  = (r_cnt_q == r_len_q);
        if (RREADY) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d  = r_addr_q + ADDR_WIDTH'(4);
            r_cnt_d   = r_cnt_q + 8'd1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      up_q      <= 1'b0;
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      w_lerr_q  <= 1'b0;
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_err_q   <= 1'b0;
    end else begin
      up_q      <= 1'b1;
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      w_lerr_q  <= w_lerr_d;
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_err_q   <= r_err_d;
    end
  end

  // Memory contents survive reset, so this block has no reset branch.
  always_ff @(posedge ACLK) begin
    if (mem_we) mem[w_addr_q[IDX_W+1:2]] <= WDATA;
    if (mem_re) rdata_q <= mem[r_addr_q[IDX_W+1:2]];
  end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: reset, single and burst transfers, error
// responses, backpressure, WLAST mismatch and reset in the middle of a burst.
module tb_axi4_mem_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [15:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic do_write(input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [31:0] base,
                          input bit bad_last, input int bwait,
                          input logic [1:0] exp_resp, input string tag);
    int n;
    bit to;
    to = 1'b0;
    AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) to = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA  = base + 32'(i);
      WLAST  = (i == int'(len)) ? !bad_last : 1'b0;
      WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
      if (n >= 50) to = 1'b1;
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk({tag, " b_latency"}, 64'(BVALID), 64'd1);
    repeat (bwait) begin
      chk({tag, " b_hold"}, 64'({BVALID, BRESP}), 64'({1'b1, exp_resp}));
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) to = 1'b1;
    chk({tag, " bresp"}, 64'(BRESP), 64'(exp_resp));
    @(negedge ACLK);
    BREADY = 1'b0;
    chk({tag, " b_done"}, 64'(BVALID), 64'd0);
    chk({tag, " timeout"}, 64'(to), 64'd0);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [31:0] base,
                         input bit err, input bit stall, input string tag);
    int n;
    bit to;
    logic [31:0] d;
    to = 1'b0;
    ARADDR = addr; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) to = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk({tag, " r_fetch"}, 64'(RVALID), 64'd0);
    @(negedge ACLK);
    chk({tag, " r_latency"}, 64'(RVALID), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
      if (n >= 50) to = 1'b1;
      d = err ? 32'h0 : base + 32'(i);
      if (stall) begin
        RREADY = 1'b0;
        @(negedge ACLK);
        chk({tag, " r_stall"}, {27'h0, RVALID, RDATA, RRESP, RLAST},
            {27'h0, 1'b1, d, (err ? 2'b10 : 2'b00), (i == int'(len))});
      end
      chk({tag, " r_beat"}, {27'h0, RVALID, RDATA, RRESP, RLAST},
          {27'h0, 1'b1, d, (err ? 2'b10 : 2'b00), (i == int'(len))});
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
    chk({tag, " r_done"}, 64'(RVALID), 64'd0);
    chk({tag, " timeout"}, 64'(to), 64'd0);
  endtask

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
    WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset held three cycles: every output low throughout.
    repeat (3) begin
      @(negedge ACLK);
      chk("rst ctrl", 64'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST}), 64'd0);
      chk("rst rdata", 64'(RDATA), 64'd0);
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst release ready", 64'({AWREADY, ARREADY}), 64'b11);

    // Single beat write and readback.
    do_write(16'h0010, 8'd0, 3'd2, 32'hDEADBEEF, 1'b0, 0, 2'b00, "single wr");
    do_read (16'h0010, 8'd0, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, "single rd");

    // Four-beat burst, read back with RREADY stalls.
    do_write(16'h0100, 8'd3, 3'd2, 32'd1, 1'b0, 0, 2'b00, "burst wr");
    do_read (16'h0100, 8'd3, 3'd2, 32'd1, 1'b0, 1'b1, "burst rd");

    // Error cases: boundary crossing leaves the last word intact.
    do_write(16'h0FFC, 8'd0, 3'd2, 32'h5A5A5A5A, 1'b0, 0, 2'b00, "top wr");
    do_write(16'h0FFC, 8'd1, 3'd2, 32'h12345678, 1'b0, 0, 2'b10, "cross wr");
    do_read (16'h0FFC, 8'd0, 3'd2, 32'h5A5A5A5A, 1'b0, 1'b0, "top rd");
    do_write(16'h0020, 8'd0, 3'd1, 32'hCAFEF00D, 1'b0, 0, 2'b10, "size wr");
    do_read (16'h0002, 8'd0, 3'd2, 32'h0, 1'b1, 1'b0, "unalign rd");

    // BREADY held off five cycles, WLAST missing on the final beat.
    do_write(16'h0200, 8'd1, 3'd2, 32'h11, 1'b1, 5, 2'b10, "wlast wr");
    do_read (16'h0200, 8'd1, 3'd2, 32'h11, 1'b0, 1'b0, "wlast rd");

    // Reset during beat index 2 of an eight-beat write.
    do_write(16'h0308, 8'd0, 3'd2, 32'h77777777, 1'b0, 0, 2'b00, "pre wr");
    AWADDR = 16'h0300; AWLEN = 8'd7; AWSIZE = 3'd2; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WDATA = 32'hA0 + 32'(i); WLAST = 1'b0; WVALID = 1'b1;
      @(negedge ACLK);
    end
    WDATA = 32'hA2; ARESET = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      chk("midrst outs", 64'({AWREADY, WREADY, BVALID, ARREADY, RVALID}), 64'd0);
    end
    ARESET = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    chk("midrst ready", 64'({AWREADY, ARREADY}), 64'b11);
    repeat (3) begin
      @(negedge ACLK);
      chk("midrst no b", 64'(BVALID), 64'd0);
    end
    do_read(16'h0300, 8'd0, 3'd2, 32'hA0, 1'b0, 1'b0, "midrst b0");
    do_read(16'h0304, 8'd0, 3'd2, 32'hA1, 1'b0, 1'b0, "midrst b1");
    do_read(16'h0308, 8'd0, 3'd2, 32'h77777777, 1'b0, 1'b0, "midrst b2");
    do_read(16'h0010, 8'd0, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, "retained");
    do_write(16'h0400, 8'd1, 3'd2, 32'h55, 1'b0, 0, 2'b00, "post wr");
    do_read (16'h0400, 8'd1, 3'd2, 32'h55, 1'b0, 1'b1, "post rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
